// File: rtl/ir_receiver.sv
// IR packet receiver: recovers bursts and gaps from a carrier-modulated IR
// pulse train by counting synchronized carrier edges, then decodes the
// START / SELECT / Right / Left / Backward / Forward packet into a 4-bit command.
module ir_receiver #(
  parameter int unsigned CARRIER_HALF = 1389,
  parameter int unsigned START_LEN    = 191,
  parameter int unsigned SEL_LEN      = 47,
  parameter int unsigned ASSERT_LEN   = 47,
  parameter int unsigned DEASSERT_LEN = 22,
  parameter int unsigned GAP_LEN      = 25,
  parameter int unsigned TOL          = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ir_in,
  output logic [3:0] o_cmd,
  output logic       o_cmd_valid,
  output logic       o_pkt_err
);

  localparam int unsigned PERIOD  = 2 * CARRIER_HALF;
  localparam int unsigned SUB_W   = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned GAP_MAX = GAP_LEN + TOL;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SELECT,
    BIT_R,
    BIT_L,
    BIT_B,
    BIT_F
  } state_t;

  logic [1:0]       r_sync;
  logic             r_sync_d;
  logic [SUB_W-1:0] r_sub;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_burst;
  logic [CNT_W-1:0] r_gap_len;
  logic             r_in_burst;
  logic [2:0]       r_bits;
  state_t           r_state;

  logic w_edge;
  logic w_timeout;
  logic w_gap_over;
  logic w_gap_ok;
  logic w_is_start;
  logic w_is_sel;
  logic w_is_one;
  logic w_is_zero;
  logic w_bit_ok;
  logic w_elem_ok;

  // True when len lies within +/-TOL of nom (written to avoid unsigned underflow)
  function automatic logic len_match(input logic [CNT_W-1:0] len, input int unsigned nom);
    return ((32'(len) + TOL) >= nom) && (32'(len) <= (nom + TOL));
  endfunction

  // Two-flop synchronizer plus one delay flop for rising-edge detection
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], i_ir_in};
      r_sync_d <= r_sync[1];
    end
  end

  assign w_edge = r_sync[1] & ~r_sync_d;

  // Elapsed time since the last edge, kept as whole carrier periods (r_gap)
  // plus clocks into the current period (r_sub); r_gap saturates
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sub <= '0;
      r_gap <= '0;
    end else if (w_edge) begin
      r_sub <= SUB_W'(1);
      r_gap <= '0;
    end else if (r_sub == SUB_W'(PERIOD - 1)) begin
      r_sub <= '0;
      if (r_gap != CNT_MAX) r_gap <= r_gap + CNT_W'(1);
    end else begin
      r_sub <= r_sub + SUB_W'(1);
    end
  end

  // A burst ends once 3 half-periods (one period plus a half) pass without an edge
  assign w_timeout  = r_in_burst & ~w_edge & (r_gap == CNT_W'(1)) &
                      (r_sub == SUB_W'(CARRIER_HALF));
  assign w_gap_over = ~r_in_burst & (32'(r_gap) > GAP_MAX);

  // Burst edge counter; the preceding gap is captured on the first edge
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_in_burst <= 1'b0;
      r_burst    <= '0;
      r_gap_len  <= '0;
    end else if (w_edge) begin
      r_in_burst <= 1'b1;
      if (!r_in_burst) begin
        r_burst   <= CNT_W'(1);
        r_gap_len <= r_gap;
      end else if (r_burst != CNT_MAX) begin
        r_burst <= r_burst + CNT_W'(1);
      end
    end else if (w_timeout) begin
      r_in_burst <= 1'b0;
    end
  end

  assign w_gap_ok   = len_match(r_gap_len, GAP_LEN);
  assign w_is_start = len_match(r_burst, START_LEN);
  assign w_is_sel   = len_match(r_burst, SEL_LEN);
  assign w_is_one   = len_match(r_burst, ASSERT_LEN);
  assign w_is_zero  = len_match(r_burst, DEASSERT_LEN);
  assign w_bit_ok   = w_is_one | w_is_zero;

  // Whether the gap+burst just completed is what the current state expects
  always_comb begin
    w_elem_ok = 1'b0;
    case (r_state)
      START:                       w_elem_ok = w_gap_ok & w_is_sel;
      SELECT, BIT_R, BIT_L, BIT_B: w_elem_ok = w_gap_ok & w_bit_ok;
      default:                     w_elem_ok = 1'b0;
    endcase
  end

  // Packet decoder. The Forward burst completes the packet straight from
  // BIT_B, so BIT_F is never held and simply falls back to IDLE if reached.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_bits      <= '0;
      o_cmd       <= '0;
      o_cmd_valid <= 1'b0;
      o_pkt_err   <= 1'b0;
    end else begin
      o_cmd_valid <= 1'b0;
      o_pkt_err   <= 1'b0;
      if (w_timeout) begin
        if (r_state == IDLE) begin
          if (w_is_start) r_state <= START;
        end else if (!w_elem_ok) begin
          // Malformed element; the same burst may still open a new packet
          o_pkt_err <= 1'b1;
          r_state   <= w_is_start ? START : IDLE;
        end else begin
          case (r_state)
            START: r_state <= SELECT;
            SELECT: begin
              r_bits[2] <= w_is_one;
              r_state   <= BIT_R;
            end
            BIT_R: begin
              r_bits[1] <= w_is_one;
              r_state   <= BIT_L;
            end
            BIT_L: begin
              r_bits[0] <= w_is_one;
              r_state   <= BIT_B;
            end
            BIT_B: begin
              o_cmd       <= {r_bits, w_is_one};
              o_cmd_valid <= 1'b1;
              r_state     <= IDLE;
            end
            default: r_state <= IDLE;
          endcase
        end
      end else if (w_gap_over && (r_state != IDLE)) begin
        // Gap grew past the allowed maximum: abandon the packet immediately
        o_pkt_err <= 1'b1;
        r_state   <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ir_receiver.sv
// Self-checking bench for ir_receiver: drives carrier bursts/gaps and compares
// the decoded event stream against a packet-level reference model.
module tb_ir_receiver;

  localparam int unsigned H = 2;
  localparam int unsigned P = 2 * H;
  localparam int START_LEN = 191;
  localparam int SEL_LEN = 47;
  localparam int ASSERT_LEN = 47;
  localparam int DEASSERT_LEN = 22;
  localparam int GAP_LEN = 25;
  localparam int TOL = 4;
  localparam int EV_ERR = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ir = 1'b0;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       pkt_err;

  int          checks = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned last_rise = 0;

  int          obs_q[$];
  int unsigned obs_cyc[$];
  bit          both_seen = 1'b0;

  // Reference model: position within the packet (0 = waiting for START,
  // 1 = START seen, 2 = SELECT seen, 3..5 = bits R..B collected)
  int         pos = 0;
  logic [3:0] mbits = 4'b0;
  logic [3:0] mcmd = 4'b0;
  int         exp_q[$];

  ir_receiver #(.CARRIER_HALF(H)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_ir_in    (ir),
    .o_cmd      (cmd),
    .o_cmd_valid(cmd_valid),
    .o_pkt_err  (pkt_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (cmd_valid && pkt_err) both_seen = 1'b1;
    if (cmd_valid) begin
      obs_q.push_back(16 + int'(cmd));
      obs_cyc.push_back(cyc);
    end
    if (pkt_err) begin
      obs_q.push_back(EV_ERR);
      obs_cyc.push_back(cyc);
    end
  end

  function automatic bit in_tol(input int len, input int nom);
    return (len >= nom - TOL) && (len <= nom + TOL);
  endfunction

  task automatic model_reset();
    pos = 0;
    mbits = 4'b0;
    mcmd = 4'b0;
  endtask

  task automatic model_burst(input int gap, input int len);
    bit ok;
    bit one;
    if (pos != 0 && gap > GAP_LEN + TOL) begin
      exp_q.push_back(EV_ERR);
      pos = 0;
    end
    if (pos == 0) begin
      if (in_tol(len, START_LEN)) pos = 1;
      return;
    end
    ok  = in_tol(gap, GAP_LEN);
    one = in_tol(len, ASSERT_LEN);
    if (pos == 1) ok = ok && in_tol(len, SEL_LEN);
    else ok = ok && (one || in_tol(len, DEASSERT_LEN));
    if (!ok) begin
      exp_q.push_back(EV_ERR);
      pos = in_tol(len, START_LEN) ? 1 : 0;
    end else if (pos == 1) begin
      pos = 2;
    end else begin
      mbits = {mbits[2:0], one};
      if (pos == 5) begin
        mcmd = mbits;
        exp_q.push_back(16 + int'(mcmd));
        pos = 0;
      end else begin
        pos++;
      end
    end
  endtask

  task automatic model_quiet(input int n);
    if (pos != 0 && n > GAP_LEN + TOL) exp_q.push_back(EV_ERR);
    pos = 0;
  endtask

  function automatic bit q_equal();
    if (obs_q.size() != exp_q.size()) return 1'b0;
    foreach (obs_q[i]) if (obs_q[i] != exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string q_str(input int q[$]);
    string s;
    logic [3:0] v;
    s = "";
    foreach (q[i]) begin
      if (q[i] == EV_ERR) s = {s, " ERR"};
      else begin
        v = 4'(q[i] - 16);
        s = {s, $sformatf(" V%b", v)};
      end
    end
    return s;
  endfunction

  task automatic clear_q();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic idle_clocks(input int n);
    ir = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic carrier(input int n);
    for (int i = 0; i < n; i++) begin
      last_rise = cyc;
      ir = 1'b1;
      repeat (H) @(negedge clk);
      ir = 1'b0;
      repeat (H) @(negedge clk);
    end
  endtask

  // Gap of 'gap' whole periods measured rising-edge to rising-edge, then a burst
  task automatic send_burst(input int gap, input int len);
    idle_clocks((gap - 1) * P + H);
    model_burst(gap, len);
    carrier(len);
  endtask

  task automatic quiet(input int n);
    model_quiet(n);
    idle_clocks(n * P);
  endtask

  task automatic send_packet(input logic [3:0] bits, input int start_gap);
    send_burst(start_gap, START_LEN);
    send_burst(GAP_LEN, SEL_LEN);
    for (int i = 3; i >= 0; i--) send_burst(GAP_LEN, bits[i] ? ASSERT_LEN : DEASSERT_LEN);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (cmd !== 4'b0000) begin fails++; $display("FAIL reset_cmd got %b want 0000", cmd); end
    checks++;
    if (cmd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", cmd_valid); end
    checks++;
    if (pkt_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", pkt_err); end
    rst = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL reset_quiet got %0d events want 0", obs_q.size()); end
    clear_q();
  endtask

  task automatic test_nominal();
    int unsigned lr;
    send_packet(4'b1001, GAP_LEN);
    lr = last_rise;
    quiet(40);
    checks++;
    if (!q_equal()) begin
      fails++; $display("FAIL nominal_events got [%s] want [%s]", q_str(obs_q), q_str(exp_q));
    end
    checks++;
    if (cmd !== 4'b1001) begin fails++; $display("FAIL nominal_cmd got %b want 1001", cmd); end
    checks++;
    if (obs_cyc.size() == 0 || obs_cyc[0] != lr + 3 * H + 3) begin
      fails++;
      $display("FAIL latency got %0d clocks want %0d", (obs_cyc.size() == 0) ? -1 : int'(obs_cyc[0] - lr), 3 * H + 3);
    end
    clear_q();
  endtask

  task automatic test_tolerance();
    send_burst(GAP_LEN, 187);
    send_burst(21, 47);
    send_burst(29, 51);
    send_burst(21, 18);
    send_burst(29, 51);
    send_burst(21, 18);
    quiet(40);
    checks++;
    if (!q_equal()) begin
      fails++; $display("FAIL tol_events got [%s] want [%s]", q_str(obs_q), q_str(exp_q));
    end
    checks++;
    if (cmd !== 4'b1010) begin fails++; $display("FAIL tol_cmd got %b want 1010", cmd); end
    clear_q();
    send_burst(GAP_LEN, 186);
    send_burst(GAP_LEN, SEL_LEN);
    send_burst(GAP_LEN, ASSERT_LEN);
    send_burst(GAP_LEN, DEASSERT_LEN);
    quiet(40);
    checks++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL tol_reject got [%s] want []", q_str(obs_q)); end
    checks++;
    if (cmd !== 4'b1010) begin fails++; $display("FAIL tol_reject_cmd got %b want 1010", cmd); end
    clear_q();
  endtask

  task automatic test_long_gap();
    int unsigned lr;
    send_burst(GAP_LEN, START_LEN);
    send_burst(GAP_LEN, SEL_LEN);
    send_burst(GAP_LEN, DEASSERT_LEN);
    send_burst(GAP_LEN, ASSERT_LEN);
    lr = last_rise;
    send_burst(40, ASSERT_LEN);
    send_burst(GAP_LEN, ASSERT_LEN);
    quiet(40);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] != EV_ERR) begin
      fails++; $display("FAIL long_gap_err got [%s] want [ ERR]", q_str(obs_q));
    end
    checks++;
    if (obs_cyc.size() == 0 || obs_cyc[0] != lr + (GAP_LEN + TOL + 1) * P + 3) begin
      fails++;
      $display("FAIL long_gap_time got %0d clocks want %0d", (obs_cyc.size() == 0) ? -1 : int'(obs_cyc[0] - lr), (GAP_LEN + TOL + 1) * P + 3);
    end
    checks++;
    if (cmd !== mcmd) begin fails++; $display("FAIL long_gap_hold got %b want %b", cmd, mcmd); end
    clear_q();
    send_packet(4'b0110, GAP_LEN);
    quiet(40);
    checks++;
    if (!q_equal()) begin
      fails++; $display("FAIL long_gap_next got [%s] want [%s]", q_str(obs_q), q_str(exp_q));
    end
    checks++;
    if (cmd !== 4'b0110) begin fails++; $display("FAIL long_gap_next_cmd got %b want 0110", cmd); end
    clear_q();
  endtask

  task automatic test_resync();
    send_burst(GAP_LEN, START_LEN);
    send_burst(GAP_LEN, 35);
    send_packet(4'b0011, GAP_LEN);
    send_burst(GAP_LEN, START_LEN);
    send_burst(GAP_LEN, SEL_LEN);
    send_burst(GAP_LEN, ASSERT_LEN);
    send_burst(GAP_LEN, START_LEN);
    send_burst(GAP_LEN, SEL_LEN);
    send_burst(GAP_LEN, ASSERT_LEN);
    send_burst(GAP_LEN, ASSERT_LEN);
    send_burst(GAP_LEN, DEASSERT_LEN);
    send_burst(GAP_LEN, DEASSERT_LEN);
    quiet(40);
    checks++;
    if (!q_equal()) begin
      fails++; $display("FAIL resync_events got [%s] want [%s]", q_str(obs_q), q_str(exp_q));
    end
    checks++;
    if (obs_q.size() != 4 || obs_q[0] != EV_ERR || obs_q[1] != 16 + 3 || obs_q[2] != EV_ERR || obs_q[3] != 16 + 12) begin
      fails++; $display("FAIL resync_seq got [%s] want [ ERR V0011 ERR V1100]", q_str(obs_q));
    end
    checks++;
    if (cmd !== 4'b1100) begin fails++; $display("FAIL resync_cmd got %b want 1100", cmd); end
    clear_q();
  endtask

  task automatic test_back_to_back();
    send_packet(4'b0101, GAP_LEN);
    send_packet(4'b1010, 200);
    quiet(40);
    checks++;
    if (!q_equal()) begin
      fails++; $display("FAIL b2b_events got [%s] want [%s]", q_str(obs_q), q_str(exp_q));
    end
    checks++;
    if (obs_q.size() != 2 || obs_q[0] != 16 + 5 || obs_q[1] != 16 + 10) begin
      fails++; $display("FAIL b2b_seq got [%s] want [ V0101 V1010]", q_str(obs_q));
    end
    clear_q();
  endtask

  task automatic test_reset_mid();
    send_burst(GAP_LEN, START_LEN);
    send_burst(GAP_LEN, SEL_LEN);
    send_burst(GAP_LEN, ASSERT_LEN);
    send_burst(GAP_LEN, DEASSERT_LEN);
    idle_clocks((GAP_LEN - 1) * P + H);
    carrier(20);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (cmd !== 4'b0000 || cmd_valid !== 1'b0 || pkt_err !== 1'b0) begin
      fails++; $display("FAIL reset_mid_now got cmd=%b v=%b e=%b want 0000/0/0", cmd, cmd_valid, pkt_err);
    end
    #29 rst = 1'b0;
    @(negedge clk);
    model_reset();
    carrier(ASSERT_LEN - 20);
    send_burst(GAP_LEN, ASSERT_LEN);
    quiet(40);
    checks++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL reset_mid_events got [%s] want []", q_str(obs_q)); end
    checks++;
    if (cmd !== 4'b0000) begin fails++; $display("FAIL reset_mid_cmd got %b want 0000", cmd); end
    clear_q();
  endtask

  task automatic test_constant();
    ir = 1'b1;
    repeat (1500) @(negedge clk);
    ir = 1'b0;
    repeat (1500) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL constant_events got [%s] want []", q_str(obs_q)); end
    checks++;
    if (cmd !== mcmd) begin fails++; $display("FAIL constant_cmd got %b want %b", cmd, mcmd); end
    clear_q();
  endtask

  task automatic test_random();
    int bad_len[6];
    int gap;
    int len;
    int r;
    bad_len = '{35, 42, 52, 17, 27, 191};
    for (int k = 0; k < 10; k++) begin
      len = ($urandom_range(0, 9) < 8) ? int'($urandom_range(187, 195)) : (($urandom_range(0, 1) != 0) ? 186 : 196);
      send_burst(GAP_LEN, len);
      for (int e = 0; e < 5; e++) begin
        r = int'($urandom_range(0, 9));
        gap = (r < 7) ? int'($urandom_range(21, 29)) : (r == 7) ? 20 : (r == 8) ? 30 : GAP_LEN;
        if ($urandom_range(0, 9) < 8) begin
          if (e == 0) len = int'($urandom_range(43, 51));
          else len = ($urandom_range(0, 1) != 0) ? int'($urandom_range(43, 51)) : int'($urandom_range(18, 26));
        end else begin
          len = bad_len[$urandom_range(0, 5)];
        end
        send_burst(gap, len);
      end
      quiet(40);
      checks++;
      if (!q_equal()) begin
        fails++; $display("FAIL random_%0d_events got [%s] want [%s]", k, q_str(obs_q), q_str(exp_q));
      end
      checks++;
      if (cmd !== mcmd) begin fails++; $display("FAIL random_%0d_cmd got %b want %b", k, cmd, mcmd); end
      clear_q();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_tolerance();
    test_long_gap();
    test_resync();
    test_back_to_back();
    test_reset_mid();
    test_constant();
    test_random();
    checks++;
    if (both_seen) begin fails++; $display("FAIL exclusive got valid&err together want never"); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ir_receiver.md
IR_RECEIVER -- requirements
Module: ir_receiver

Interface
REQ-001 Parameter CARRIER_HALF, default 1389: clocks per carrier half-period (36 kHz at 100 MHz CLK).
REQ-002 Parameters START_LEN 191, SEL_LEN 47, ASSERT_LEN 47, DEASSERT_LEN 22, GAP_LEN 25: nominal lengths in carrier periods.
REQ-003 Parameter TOL, default 4: allowed +/- deviation, in carrier periods, for every burst and gap.
REQ-004 CLK  input  1  system clock, single clock domain.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 IR_IN  input  1  asynchronous carrier-modulated IR pulse train; the receiving end of the IR_LED packet protocol.
REQ-007 CMD  output  4  last decoded command {Right, Left, Backward, Forward}, bit 3 = Right.
REQ-008 CMD_VALID  output  1  one-cycle pulse when CMD updates.
REQ-009 PKT_ERR  output  1  one-cycle pulse on a malformed packet.

Function
REQ-010 IR_IN SHALL pass through a 2-flop synchronizer; a carrier edge is a 0->1 transition on the synchronized signal.
REQ-011 A carrier period SHALL be 2*CARRIER_HALF clocks; a free-running period tick is not used -- all lengths are counted from edges.
REQ-012 Burst length SHALL equal the number of carrier edges in the burst; a burst ends when no edge arrives for 3*CARRIER_HALF clocks after the last edge.
REQ-013 Gap length SHALL be floor(clocks from last edge of a burst to first edge of the next / (2*CARRIER_HALF)); counters saturate, never wrap.
REQ-014 A length L matches nominal N iff N-TOL <= L <= N+TOL.
REQ-015 FSM states: IDLE, START, SELECT, BIT_R, BIT_L, BIT_B, BIT_F; each state after IDLE consumes one preceding gap and one burst.
REQ-016 IDLE: any burst matching START_LEN -> START; any other burst ignored, no PKT_ERR; gap before start unchecked.
REQ-017 START: next gap must match GAP_LEN and burst must match SEL_LEN -> SELECT.
REQ-018 SELECT through BIT_B: gap must match GAP_LEN; burst matching ASSERT_LEN records 1, DEASSERT_LEN records 0; advance R->L->B->F.
REQ-019 Burst ambiguous (matches both ASSERT and DEASSERT) SHALL decode as 1.
REQ-020 After BIT_F burst completes: CMD <= collected bits and CMD_VALID pulses in the same cycle; FSM -> IDLE.
REQ-021 Error: gap exceeding GAP_LEN+TOL (detected as soon as the count passes it), gap below GAP_LEN-TOL, or burst matching no allowed length outside IDLE -> PKT_ERR pulse, FSM -> IDLE, CMD unchanged.
REQ-022 An erroring burst SHALL also be re-evaluated as a candidate START burst in the same cycle (resynchronisation).
REQ-023 Latency: CMD_VALID asserts exactly 3*CARRIER_HALF+3 clocks after the last raw IR_IN rising edge of the Forward burst (2 sync + timeout + 1 register).
REQ-024 CMD_VALID and PKT_ERR SHALL never assert in the same cycle.
REQ-025 IR_IN held constant high or low SHALL never produce edges, hence never CMD_VALID.

Reset
REQ-026 RESET high SHALL immediately force: FSM IDLE, CMD 4'b0000, CMD_VALID 0, PKT_ERR 0, all counters and synchronizer flops 0.
REQ-027 RESET mid-packet SHALL discard the partial packet; decoding restarts only at a fresh START burst after release.
REQ-028 Outputs are registered; no output depends combinationally on IR_IN.

Verification
REQ-029 Nominal packet (191/25/47/25 then bursts 47,22,22,47 with 25 gaps) -> one CMD_VALID, CMD=4'b1001, PKT_ERR 0.
REQ-030 Bursts at tolerance edges (187 start, 51 assert, 18 deassert, gaps 21/29) -> accepted, CMD decoded; 186 start -> ignored, no pulses.
REQ-031 Gap of 40 periods after BIT_L -> PKT_ERR pulse at gap count 30, CMD retains prior value, next valid packet decodes.
REQ-032 RESET pulse (asserted 30 ns) during BIT_B burst -> CMD=0 immediately, no CMD_VALID for that packet.
REQ-033 Two back-to-back packets 0101 then 1010 separated by 200-period gap -> two CMD_VALID pulses, CMD 4'b0101 then 4'b1010.
REQ-034 Burst of 35 periods in SELECT position followed by a 191 burst -> PKT_ERR, then START accepted and subsequent packet decoded.
